// File: rtl/io_multi_timer.sv
// io_multi_timer
//   Memory-mapped multi-channel timer for the CPU I/O space. NCH channels
//   share one free-running prescaler. Each channel occupies 16 bytes:
//     +0 CNT (rw), +4 LIM (rw), +8 CTL {IE,OVF,RDY,AR,EN}, +12 reserved (reads 0).
//   RDY/OVF are sticky and write-0-to-clear.
//   A write that lands on the same cycle as a tick wins for the written
//   register; fields that are not written still take the tick update.
//
// Ports
//   clk    in   system clock
//   rst    in   asynchronous active-low reset
//   addr   in   byte address (addr[1:0] ignored)
//   wdata  in   store data
//   we     in   store strobe, sampled on posedge clk
//   rdata  out  read data, combinational from addr (0 outside the window)
//   sel    out  addr inside [BASE_ADDR, BASE_ADDR + NCH*16)
//   irq    out  registered OR of (RDY & IE) over channels
//
// Build option
//   IO_MULTI_TIMER_IRQ_EN : when defined, IE storage and irq are built;
//                           otherwise irq is tied 0 and CTL bit4 reads 0.

module io_multi_timer #(
   parameter int unsigned      DBITS     = 32,
   parameter int unsigned      NCH       = 4,
   parameter logic [DBITS-1:0] BASE_ADDR = 32'hF0000020,
   parameter int unsigned      PRESCALE  = 50000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [DBITS-1:0] addr,
   input  logic [DBITS-1:0] wdata,
   input  logic             we,
   output logic [DBITS-1:0] rdata,
   output logic             sel,
   output logic             irq
);

   localparam int unsigned      PW  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [DBITS-1:0] WIN = DBITS'(NCH * 16);
   localparam logic [DBITS-1:0] ONE = DBITS'(1);

   // ---------------------------------------------------------------
   // Address decode
   // ---------------------------------------------------------------
   logic [DBITS-1:0] offset;
   logic             inWin;
   logic [DBITS-5:0] chSel;
   logic [1:0]       regSel;

   // Subtracting the base lets one unsigned compare cover both window bounds.
   assign offset = addr - BASE_ADDR;
   assign inWin  = (offset < WIN);
   assign chSel  = offset[DBITS-1:4];
   assign regSel = offset[3:2];
   assign sel    = inWin;

   // ---------------------------------------------------------------
   // Prescaler
   // ---------------------------------------------------------------
   logic [PW-1:0] pre;
   logic          tick;

   assign tick = (pre == PW'(PRESCALE - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pre <= '0;
      end else begin
         pre <= tick ? '0 : pre + PW'(1);
      end
   end

   // ---------------------------------------------------------------
   // Per-channel write strobes
   // ---------------------------------------------------------------
   logic [NCH-1:0] wrCnt;
   logic [NCH-1:0] wrLim;
   logic [NCH-1:0] wrCtl;

   always_comb begin
      wrCnt = '0;
      wrLim = '0;
      wrCtl = '0;
      for (int unsigned i = 0; i < NCH; i++) begin
         if (we && inWin && (chSel == (DBITS-4)'(i))) begin
            case (regSel)
               2'd0:    wrCnt[i] = 1'b1;
               2'd1:    wrLim[i] = 1'b1;
               2'd2:    wrCtl[i] = 1'b1;
               default: ;
            endcase
         end
      end
   end

   // ---------------------------------------------------------------
   // Channel state
   // ---------------------------------------------------------------
   logic [DBITS-1:0] cnt [NCH];
   logic [DBITS-1:0] lim [NCH];
   logic [NCH-1:0]   en;
   logic [NCH-1:0]   ar;
   logic [NCH-1:0]   rdy;
   logic [NCH-1:0]   ovf;
   logic [NCH-1:0]   ie;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned i = 0; i < NCH; i++) begin
            cnt[i] <= '0;
            lim[i] <= '0;
         end
         en  <= '0;
         ar  <= '0;
         rdy <= '0;
         ovf <= '0;
      end else begin
         for (int unsigned i = 0; i < NCH; i++) begin
            if (tick && en[i]) begin
               if ((lim[i] != '0) && (cnt[i] == lim[i] - ONE)) begin
                  cnt[i] <= '0;
                  rdy[i] <= 1'b1;
                  if (rdy[i]) ovf[i] <= 1'b1;
                  if (!ar[i]) en[i]  <= 1'b0;
               end else begin
                  cnt[i] <= cnt[i] + ONE;
               end
            end
            // Software writes come last so they override the tick update
            // for exactly the fields they touch.
            if (wrCnt[i]) cnt[i] <= wdata;
            if (wrLim[i]) lim[i] <= wdata;
            if (wrCtl[i]) begin
               en[i] <= wdata[0];
               ar[i] <= wdata[1];
               if (!wdata[2]) rdy[i] <= 1'b0;
               if (!wdata[3]) ovf[i] <= 1'b0;
            end
         end
      end
   end

`ifdef IO_MULTI_TIMER_IRQ_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ie <= '0;
      end else begin
         for (int unsigned i = 0; i < NCH; i++) begin
            if (wrCtl[i]) ie[i] <= wdata[4];
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         irq <= 1'b0;
      end else begin
         irq <= |(rdy & ie);
      end
   end
`else
   assign ie  = '0;
   assign irq = 1'b0;
`endif

   // ---------------------------------------------------------------
   // Read mux
   // ---------------------------------------------------------------
   always_comb begin
      rdata = '0;
      if (inWin) begin
         for (int unsigned i = 0; i < NCH; i++) begin
            if (chSel == (DBITS-4)'(i)) begin
               case (regSel)
                  2'd0:    rdata = cnt[i];
                  2'd1:    rdata = lim[i];
                  2'd2:    rdata[4:0] = {ie[i], ovf[i], rdy[i], ar[i], en[i]};
                  default: rdata = '0;
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_io_multi_timer.sv
// tb_io_multi_timer
//   Directed bench for io_multi_timer with NCH=2, PRESCALE=4. Tick edges are
//   every 4th posedge after reset release; "edges" counts posedges since
//   release so comments below refer to edge numbers.

module tb_io_multi_timer;

   localparam logic [31:0] BASE = 32'hF0000020;
`ifdef IO_MULTI_TIMER_IRQ_EN
   localparam logic [31:0] IEBIT  = 32'h10;
   localparam logic [31:0] EXPIRQ = 32'd1;
`else
   localparam logic [31:0] IEBIT  = 32'h0;
   localparam logic [31:0] EXPIRQ = 32'd0;
`endif

   logic        clk   = 1'b0;
   logic        rst   = 1'b0;
   logic [31:0] addr  = '0;
   logic [31:0] wdata = '0;
   logic        we    = 1'b0;
   logic [31:0] rdata;
   logic        sel;
   logic        irq;

   int unsigned total = 0;
   int unsigned bad   = 0;
   int unsigned edges = 0;

   io_multi_timer #(
      .DBITS    (32),
      .NCH      (2),
      .BASE_ADDR(32'hF0000020),
      .PRESCALE (4)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .addr (addr),
      .wdata(wdata),
      .we   (we),
      .rdata(rdata),
      .sel  (sel),
      .irq  (irq)
   );

   always #10 clk = ~clk;

   always @(posedge clk or negedge rst) begin
      if (!rst) edges <= 0;
      else      edges <= edges + 1;
   end

   task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic clocks(input int unsigned n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      addr  = a;
      wdata = d;
      we    = 1'b1;
      @(posedge clk);
      #1;
      we    = 1'b0;
   endtask

   task automatic rdChk(input string tag, input logic [31:0] a, input logic [31:0] exp);
      addr = a;
      #1;
      checkVal(tag, rdata, exp);
   endtask

   task automatic syncTick();
      for (int i = 0; i < 8 && (edges % 4) != 0; i++) clocks(1);
      checkVal("syncTick", edges % 4, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // ---- reset state ----
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;                     // edges = 0
      rdChk("rst_cnt0", BASE + 32'h00, 32'h0);
      rdChk("rst_lim0", BASE + 32'h04, 32'h0);
      rdChk("rst_ctl0", BASE + 32'h08, 32'h0);
      rdChk("rst_cnt1", BASE + 32'h10, 32'h0);
      rdChk("rst_lim1", BASE + 32'h14, 32'h0);
      rdChk("rst_ctl1", BASE + 32'h18, 32'h0);
      checkVal("rst_irq", {31'b0, irq}, 32'h0);
      addr = BASE + 32'h30;
      #1;
      checkVal("out_sel", {31'b0, sel}, 32'h0);
      checkVal("out_rdata", rdata, 32'h0);
      addr = BASE + 32'h1C;
      #1;
      checkVal("rsv_sel", {31'b0, sel}, 32'h1);
      checkVal("rsv_rdata", rdata, 32'h0);

      // ---- ch0 auto-reload ----
      wr(BASE + 32'h04, 32'd3);          // LIM0 @ edge1
      syncTick();                        // edge4
      wr(BASE + 32'h08, 32'h3);          // CTL0 EN|AR @ edge5
      clocks(2);                         // edge7
      rdChk("ar_cnt_e7", BASE, 32'd0);
      clocks(1);                         // edge8 tick
      rdChk("ar_cnt_e8", BASE, 32'd1);
      clocks(4);                         // edge12
      rdChk("ar_cnt_e12", BASE, 32'd2);
      clocks(4);                         // edge16 wrap
      rdChk("ar_cnt_wrap", BASE, 32'd0);
      rdChk("ar_ctl_rdy", BASE + 32'h08, 32'h7);
      rdChk("lim0_lowbits", BASE + 32'h05, 32'd3);
      clocks(12);                        // edge28 second wrap
      rdChk("ar_ctl_ovf", BASE + 32'h08, 32'hF);
      rdChk("ar_cnt_wrap2", BASE, 32'd0);

      // ---- ch1 one-shot ----
      wr(BASE + 32'h14, 32'd2);          // edge29
      wr(BASE + 32'h18, 32'h1);          // edge30
      clocks(3);                         // edge33
      rdChk("os_cnt_1", BASE + 32'h10, 32'd1);
      rdChk("os_ctl_run", BASE + 32'h18, 32'h1);
      clocks(3);                         // edge36 wrap
      rdChk("os_cnt_0", BASE + 32'h10, 32'd0);
      rdChk("os_ctl_done", BASE + 32'h18, 32'h4);
      clocks(8);                         // edge44
      rdChk("os_cnt_hold", BASE + 32'h10, 32'd0);
      rdChk("os_ctl_hold", BASE + 32'h18, 32'h4);

      // ---- write/tick collision on ch0 ----
      wr(BASE + 32'h08, 32'h3);          // clear RDY/OVF @ edge45
      rdChk("clr_ctl0", BASE + 32'h08, 32'h3);
      clocks(6);                         // edge51
      wr(BASE + 32'h08, 32'h3);          // lands on tick edge52 (wrap)
      rdChk("col_ctl0", BASE + 32'h08, 32'h3);
      rdChk("col_cnt0", BASE, 32'd0);
      clocks(12);                        // edge64 wrap sets RDY
      rdChk("w1_pre", BASE + 32'h08, 32'h7);
      wr(BASE + 32'h08, 32'h4);          // edge65: RDY kept, EN/AR off
      rdChk("w1_rdy_kept", BASE + 32'h08, 32'h4);
      wr(BASE, 32'd5);                   // edge66
      clocks(8);                         // edge74, ticks 68/72 ignored
      rdChk("en0_hold", BASE, 32'd5);

      // ---- irq ----
      syncTick();                        // edge76
      wr(BASE, 32'd0);                   // edge77
      wr(BASE + 32'h08, 32'h13);         // edge78: IE|AR|EN, RDY cleared
      clocks(10);                        // edge88 wrap
      rdChk("irq_ctl_rdy", BASE + 32'h08, 32'h7 | IEBIT);
      checkVal("irq_lat0", {31'b0, irq}, 32'h0);
      clocks(1);                         // edge89
      checkVal("irq_rise", {31'b0, irq}, EXPIRQ);
      wr(BASE + 32'h08, 32'h13);         // clear RDY @ edge90
      checkVal("irq_hold", {31'b0, irq}, EXPIRQ);
      rdChk("irq_ctl_clr", BASE + 32'h08, 32'h3 | IEBIT);
      clocks(1);                         // edge91
      checkVal("irq_fall", {31'b0, irq}, 32'h0);

      // ---- asynchronous reset mid-count ----
      clocks(5);                         // edge96, CNT0=2
      rdChk("pre_rst_cnt0", BASE, 32'd2);
      rst = 1'b0;
      #1;
      rdChk("arst_cnt0", BASE + 32'h00, 32'h0);
      rdChk("arst_lim0", BASE + 32'h04, 32'h0);
      rdChk("arst_ctl0", BASE + 32'h08, 32'h0);
      rdChk("arst_cnt1", BASE + 32'h10, 32'h0);
      rdChk("arst_lim1", BASE + 32'h14, 32'h0);
      rdChk("arst_ctl1", BASE + 32'h18, 32'h0);
      checkVal("arst_irq", {31'b0, irq}, 32'h0);
      @(posedge clk);
      #1 rst = 1'b1;                     // edges = 0
      wr(BASE + 32'h08, 32'h1);          // EN, LIM=0 @ edge1
      clocks(2);                         // edge3
      rdChk("rel_cnt_e3", BASE, 32'd0);
      clocks(1);                         // edge4 first tick
      rdChk("rel_cnt_e4", BASE, 32'd1);
      wr(BASE, 32'hFFFF_FFFF);           // edge5
      clocks(3);                         // edge8 tick wraps
      rdChk("free_wrap", BASE, 32'd0);
      rdChk("free_no_rdy", BASE + 32'h08, 32'h1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
